event_count_bcd_converter: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the

---
 rtl/event_count_bcd_converter.sv | 55 +++++
 tb/tb_event_count_bcd_converter.sv | 119 +++++++++++
 2 files changed

// File: rtl/event_count_bcd_converter.sv
// event_count_bcd_converter: iterative shift-add-3 binary-to-BCD converter, one bit per clock
module event_count_bcd_converter #(
   parameter int BIN_WIDTH = 32,
   parameter int DIGITS    = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BIN_WIDTH-1:0]   data_in,
   input  logic                   data_valid,
   output logic                   busy,
   output logic [4*DIGITS-1:0]    bcd_out,
   output logic                   bcd_valid,
   output logic                   dropped
);
   localparam int ITW = $clog2(BIN_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
   state_t state, state_n;
   logic [BIN_WIDTH-1:0] bin_sr;
   logic [4*DIGITS-1:0] scratch, adj;
   logic [ITW-1:0] iter;
   assign busy = state != IDLE;
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
      state_n = state == IDLE  ? (data_valid ? SHIFT : IDLE) :
                state == SHIFT ? (iter == ITW'(BIN_WIDTH - 1) ? LOAD : SHIFT) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         bin_sr    <= '0;
         scratch   <= '0;
         iter      <= '0;
         bcd_out   <= '0;
         bcd_valid <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state     <= state_n;
         bcd_valid <= state == LOAD;
         dropped   <= data_valid && state != IDLE;
         if (state == IDLE && data_valid) begin
            bin_sr  <= data_in;
            scratch <= '0;
            iter    <= '0;
         end
         // adjusted digits shift left together with the next binary bit
         if (state == SHIFT) begin
            {scratch, bin_sr} <= {adj, bin_sr} << 1;
            iter              <= iter + ITW'(1);
         end
         if (state == LOAD) bcd_out <= scratch;
      end
   end
endmodule

// File: tb/tb_event_count_bcd_converter.sv
// tb_event_count_bcd_converter: directed and random checks of the BCD converter
module tb_event_count_bcd_converter;
   logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0;
   logic [31:0] data_in = '0;
   logic busy, bcd_valid, dropped;
   logic [39:0] bcd_out;
   int total = 0, bad = 0, nvalid = 0;
   always #5 clk = ~clk;
   event_count_bcd_converter dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .dropped(dropped)
   );
   always @(posedge clk) if (bcd_valid) nvalid++;
   task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [39:0] ref_bcd(input logic [31:0] v);
      logic [39:0] r = '0;
      longint unsigned x = v;
      for (int i = 0; i < 10; i++) begin
         r[4*i+:4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
   task convert(input logic [31:0] v, output logic [39:0] res, output int lat);
      data_in = v;
      data_valid = 1'b1;
      tick;
      data_valid = 1'b0;
      data_in = $urandom;
      chk("busy_after_capture", busy, 1);
      lat = 0;
      res = '0;
      for (int c = 1; c <= 60 && lat == 0; c++) begin
         tick;
         if (bcd_valid) begin
            lat = c;
            res = bcd_out;
            chk("busy_at_valid", busy, 0);
         end
      end
      if (lat == 0) chk("valid_timeout", bcd_valid, 1);
      tick;
      chk("valid_pulse_len", bcd_valid, 0);
   endtask
   logic [31:0] vin [5] = '{32'd0, 32'hFFFF_FFFF, 32'd100_000_000, 32'd12345, 32'd99_999_999};
   logic [39:0] vexp [5] = '{40'h00_0000_0000, 40'h42_9496_7295, 40'h01_0000_0000,
                             40'h00_0001_2345, 40'h00_9999_9999};
   initial begin
      logic [39:0] res, r1, r2;
      logic [31:0] v;
      int lat, d, c1, c2, n0;
      repeat (3) tick;
      chk("rst_busy", busy, 0);
      chk("rst_bcd_out", bcd_out, 0);
      chk("rst_bcd_valid", bcd_valid, 0);
      chk("rst_dropped", dropped, 0);
      reset = 1'b1;
      tick;
      for (int i = 0; i < 5; i++) begin
         convert(vin[i], res, lat);
         chk("dir_result", res, vexp[i]);
         chk("dir_latency", lat, 33);
      end
      // strobes at k+5 and k+33 are dropped; the one at k+34 lands on bcd_valid and is accepted
      data_in = 32'd12345;
      data_valid = 1'b1;
      tick;
      d = 0; c1 = 0; c2 = 0; r1 = '0; r2 = '0;
      for (int c = 1; c <= 70; c++) begin
         data_valid = (c == 5 || c == 33 || c == 34);
         data_in = data_valid ? 32'd777 : $urandom;
         tick;
         data_valid = 1'b0;
         if (dropped) d++;
         if (bcd_valid && c1 == 0) begin c1 = c; r1 = bcd_out; end
         else if (bcd_valid) begin c2 = c; r2 = bcd_out; end
      end
      chk("drop_count", d, 2);
      chk("drop_first_result", r1, 40'h00_0001_2345);
      chk("drop_first_cycle", c1, 33);
      chk("back_to_back_result", r2, 40'h00_0000_0777);
      chk("back_to_back_cycle", c2, 67);
      data_in = 32'hFFFF_FFFF;
      data_valid = 1'b1;
      tick;
      data_valid = 1'b0;
      repeat (9) tick;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_bcd_out", bcd_out, 0);
      chk("abort_bcd_valid", bcd_valid, 0);
      n0 = nvalid;
      repeat (40) tick;
      chk("abort_no_valid", 64'(nvalid - n0), 0);
      convert(32'd42, res, lat);
      chk("post_abort_result", res, 40'h00_0000_0042);
      n0 = nvalid;
      for (int i = 0; i < 1000; i++) begin
         v = $urandom;
         convert(v, res, lat);
         chk("rand_result", res, ref_bcd(v));
      end
      chk("rand_valid_count", 64'(nvalid - n0), 1000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
